stack_cpu_core: RTL and testbench

- Parametrised, multi-cycle successor to the 16-bit stack CPU top. Generic data width, stack depth and address width.
- Fetches from an external instruction memory over a req/ack handshake and executes on an internal data stack.
- Detects stack overflow, stack underflow and illegal opcodes, and exposes run/halt/fault status to the system controller.

---
 rtl/stack_cpu_pkg.sv | 19 +
 rtl/param_stack.sv | 61 ++++++
 rtl/stack_cpu_core.sv | 133 +++++++++++++
 tb/tb_stack_cpu_core.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_cpu_pkg.sv
// Shared encodings for the stack CPU: instruction classes, ALU/jump/SYS codes,
// fault codes, FSM states and the stack operation selector.
package stack_cpu_pkg;
  localparam logic [1:0] CLS_ALU = 2'b00, CLS_JMP = 2'b01, CLS_SYS = 2'b10, CLS_LIT = 2'b11;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_NOT = 4'd5, OP_DUP = 4'd6, OP_DROP = 4'd7,
                         OP_SWAP = 4'd8, OP_ADC = 4'd9;

  localparam logic [1:0] JC_ALW = 2'b00, JC_Z = 2'b01, JC_N = 2'b10, JC_C = 2'b11;

  localparam int SYS_NOP = 0, SYS_HALT = 1;

  localparam logic [1:0] FC_NONE = 2'b00, FC_OVF = 2'b01, FC_UNF = 2'b10, FC_ILL = 2'b11;

  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_HALT, ST_FAULT} state_t;

  typedef enum logic [2:0] {SOP_NONE, SOP_PUSH, SOP_POP, SOP_POP2PUSH, SOP_REPL1, SOP_REPL2} sop_t;
endpackage

// File: rtl/param_stack.sv
// Data stack: register array plus occupancy counter, one operation per cycle.
// Top lives at r_mem[depth-1]; reads of an empty slot return 0.
module param_stack
  import stack_cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int DW    = $clog2(DEPTH + 1),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_rstN,
  input  sop_t              i_op,
  input  logic [DATA_W-1:0] i_d0,
  input  logic [DATA_W-1:0] i_d1,
  input  logic [1:0]        i_need,
  output logic [DATA_W-1:0] o_top,
  output logic [DATA_W-1:0] o_second,
  output logic [DW-1:0]     o_depth,
  output logic              o_wouldOverflow,
  output logic              o_wouldUnderflow
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DW-1:0]     r_depth;
  logic [IW-1:0]     w_pIdx, w_tIdx, w_sIdx;

  assign w_pIdx = IW'(r_depth);
  assign w_tIdx = IW'(r_depth - DW'(1));
  assign w_sIdx = IW'(r_depth - DW'(2));

  assign o_top            = (r_depth != '0)      ? r_mem[w_tIdx] : '0;
  assign o_second         = (r_depth > DW'(1))   ? r_mem[w_sIdx] : '0;
  assign o_depth          = r_depth;
  assign o_wouldOverflow  = (r_depth == DW'(DEPTH));
  assign o_wouldUnderflow = (r_depth < DW'(i_need));

  always_ff @(posedge i_clock or negedge i_rstN) begin
    if (!i_rstN) r_depth <= '0;
    else begin
      case (i_op)
        SOP_PUSH:             r_depth <= r_depth + DW'(1);
        SOP_POP, SOP_POP2PUSH: r_depth <= r_depth - DW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge i_clock) begin
    case (i_op)
      SOP_PUSH:     r_mem[w_pIdx] <= i_d0;
      SOP_POP2PUSH: r_mem[w_sIdx] <= i_d0;
      SOP_REPL1:    r_mem[w_tIdx] <= i_d0;
      SOP_REPL2: begin
        r_mem[w_tIdx] <= i_d0;
        r_mem[w_sIdx] <= i_d1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/stack_cpu_core.sv
// Multi-cycle stack CPU: FETCH over req/ack, single-cycle EXEC on param_stack,
// sticky HALT/FAULT with the fault cause latched in o_faultCode.
module stack_cpu_core
  import stack_cpu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 16,
  parameter int ADDR_W      = 12,
  localparam int INSTR_W    = DATA_W + 2,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic               i_clock,
  input  logic               i_rstN,
  input  logic               i_run,
  output logic               o_iReq,
  output logic [ADDR_W-1:0]  o_iAddr,
  input  logic               i_iAck,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [DATA_W-1:0]  o_top,
  output logic [DW-1:0]      o_depth,
  output logic               o_carry,
  output logic               o_halted,
  output logic               o_fault,
  output logic [1:0]         o_faultCode
);
  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_pc, w_pcNew;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_carry, w_carryNew;
  logic [1:0]          r_fcode, w_fc, w_need;
  sop_t                w_op, w_stkOp;
  logic [DATA_W-1:0]   w_d0, w_d1, w_top, w_sec, w_lit;
  logic [DATA_W:0]     w_add, w_sub, w_adc;
  logic                w_push, w_ill, w_halt, w_ovf, w_unf, w_exec;

  assign w_lit = r_ir[DATA_W-1:0];
  assign w_add = {1'b0, w_sec} + {1'b0, w_top};
  assign w_sub = {1'b0, w_sec} - {1'b0, w_top};
  assign w_adc = w_add + {{DATA_W{1'b0}}, r_carry};

  always_comb begin
    w_op = SOP_NONE; w_d0 = w_lit; w_d1 = w_top; w_need = 2'd0;
    w_push = 1'b0; w_ill = 1'b0; w_halt = 1'b0;
    w_pcNew = r_pc + ADDR_W'(1); w_carryNew = r_carry;
    case (r_ir[INSTR_W-1 -: 2])
      CLS_LIT: begin w_op = SOP_PUSH; w_push = 1'b1; end
      CLS_ALU: begin
        w_op = SOP_POP2PUSH; w_need = 2'd2;
        case (r_ir[3:0])
          OP_ADD:  begin w_d0 = w_add[DATA_W-1:0]; w_carryNew = w_add[DATA_W]; end
          OP_SUB:  begin w_d0 = w_sub[DATA_W-1:0]; w_carryNew = ~w_sub[DATA_W]; end
          OP_ADC:  begin w_d0 = w_adc[DATA_W-1:0]; w_carryNew = w_adc[DATA_W]; end
          OP_AND:  w_d0 = w_sec & w_top;
          OP_OR:   w_d0 = w_sec | w_top;
          OP_XOR:  w_d0 = w_sec ^ w_top;
          OP_NOT:  begin w_op = SOP_REPL1; w_need = 2'd1; w_d0 = ~w_top; end
          OP_DUP:  begin w_op = SOP_PUSH; w_need = 2'd1; w_d0 = w_top; w_push = 1'b1; end
          OP_DROP: begin w_op = SOP_POP; w_need = 2'd1; end
          OP_SWAP: begin w_op = SOP_REPL2; w_d0 = w_sec; w_d1 = w_top; end
          default: begin w_op = SOP_NONE; w_need = 2'd0; w_ill = 1'b1; end
        endcase
      end
      CLS_JMP: begin
        case (r_ir[DATA_W-1 -: 2])
          JC_ALW: w_pcNew = r_ir[ADDR_W-1:0];
          JC_Z: begin
            w_op = SOP_POP; w_need = 2'd1;
            if (w_top == '0) w_pcNew = r_ir[ADDR_W-1:0];
          end
          JC_N: begin
            w_op = SOP_POP; w_need = 2'd1;
            if (w_top[DATA_W-1]) w_pcNew = r_ir[ADDR_W-1:0];
          end
          default: if (r_carry) w_pcNew = r_ir[ADDR_W-1:0];
        endcase
      end
      default: begin
        if (w_lit == DATA_W'(SYS_HALT)) w_halt = 1'b1;
        else if (w_lit != DATA_W'(SYS_NOP)) w_ill = 1'b1;
      end
    endcase
  end

  // A faulting instruction must leave stack, PC and carry untouched.
  assign w_fc    = w_ill ? FC_ILL : w_unf ? FC_UNF : (w_push && w_ovf) ? FC_OVF : FC_NONE;
  assign w_exec  = (r_state == ST_EXEC);
  assign w_stkOp = (w_exec && w_fc == FC_NONE) ? w_op : SOP_NONE;

  param_stack #(.DATA_W(DATA_W), .DEPTH(STACK_DEPTH)) u_stack (
    .i_clock(i_clock), .i_rstN(i_rstN), .i_op(w_stkOp), .i_d0(w_d0), .i_d1(w_d1),
    .i_need(w_need), .o_top(w_top), .o_second(w_sec), .o_depth(o_depth),
    .o_wouldOverflow(w_ovf), .o_wouldUnderflow(w_unf)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_run) w_next = ST_FETCH;
      ST_FETCH: if (i_iAck) w_next = ST_EXEC;
      ST_EXEC: begin
        if (w_fc != FC_NONE) w_next = ST_FAULT;
        else if (w_halt)     w_next = ST_HALT;
        else                 w_next = i_run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT, ST_FAULT: w_next = r_state;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_rstN) begin
    if (!i_rstN) begin
      r_state <= ST_IDLE; r_pc <= '0; r_ir <= '0; r_carry <= 1'b0; r_fcode <= FC_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH && i_iAck) r_ir <= i_instr;
      if (w_exec) begin
        if (w_fc != FC_NONE) r_fcode <= w_fc;
        else begin
          r_pc    <= w_pcNew;
          r_carry <= w_carryNew;
        end
      end
    end
  end

  assign o_iReq      = (r_state == ST_FETCH);
  assign o_iAddr     = r_pc;
  assign o_top       = w_top;
  assign o_carry     = r_carry;
  assign o_halted    = (r_state == ST_HALT);
  assign o_fault     = (r_state == ST_FAULT);
  assign o_faultCode = r_fcode;
endmodule

// File: tb/tb_stack_cpu_core.sv
// Bench for stack_cpu_core: instruction-memory responder with programmable ack
// delay, ISA reference model feeding a scoreboard checked after every EXEC.
module tb_stack_cpu_core;
  logic        clk = 1'b0, rstN = 1'b0, run = 1'b0, ack = 1'b0;
  logic [17:0] instr = '0;
  logic        req, halted, fault, carry;
  logic [11:0] addr;
  logic [15:0] top;
  logic [4:0]  depth;
  logic [1:0]  fcode;

  logic        ack4 = 1'b0, req4, halted4, fault4, carry4;
  logic [17:0] instr4 = '0;
  logic [11:0] addr4;
  logic [15:0] top4;
  logic [2:0]  depth4;
  logic [1:0]  fcode4;

  always #5 clk = ~clk;

  stack_cpu_core u_dut (
    .i_clock(clk), .i_rstN(rstN), .i_run(run), .o_iReq(req), .o_iAddr(addr),
    .i_iAck(ack), .i_instr(instr), .o_top(top), .o_depth(depth), .o_carry(carry),
    .o_halted(halted), .o_fault(fault), .o_faultCode(fcode)
  );

  stack_cpu_core #(.STACK_DEPTH(4)) u_dut4 (
    .i_clock(clk), .i_rstN(rstN), .i_run(run), .o_iReq(req4), .o_iAddr(addr4),
    .i_iAck(ack4), .i_instr(instr4), .o_top(top4), .o_depth(depth4), .o_carry(carry4),
    .o_halted(halted4), .o_fault(fault4), .o_faultCode(fcode4)
  );

  int n_chk = 0, n_err = 0, n_exec = 0, ack_dly = 0, cnt = 0, lp = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] top;
    logic [4:0]  depth;
    logic        carry, halted, fault;
    logic [1:0]  fc;
    logic [11:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_stk[$];
  logic [11:0] m_pc;
  logic        m_carry, m_halt, m_fault;
  logic [1:0]  m_fc, pend;
  logic [17:0] imem [4096];

  function automatic logic [17:0] LIT(input logic [15:0] v); return {2'b11, v}; endfunction
  function automatic logic [17:0] ALU(input logic [3:0] op); return {2'b00, 12'h0, op}; endfunction
  function automatic logic [17:0] JMP(input logic [1:0] c, input logic [11:0] t);
    return {2'b01, c, 2'b00, t};
  endfunction
  localparam logic [17:0] NOP = 18'h20000, HALT = 18'h20001;

  task automatic model_exec(input logic [17:0] ins);
    exp_t e; logic [15:0] t, s, r; logic [16:0] w; logic [11:0] npc; logic [1:0] fc;
    logic c; int d;
    d = m_stk.size();
    t = (d > 0) ? m_stk[d-1] : 16'h0;
    s = (d > 1) ? m_stk[d-2] : 16'h0;
    fc = 2'd0; npc = m_pc + 12'd1; c = m_carry; r = '0;
    case (ins[17:16])
      2'b11: if (d == 16) fc = 2'd1; else m_stk.push_back(ins[15:0]);
      2'b00: begin
        if (ins[3:0] > 4'd9) fc = 2'd3;
        else if (ins[3:0] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9} && d < 2) fc = 2'd2;
        else if (ins[3:0] inside {4'd5, 4'd6, 4'd7} && d < 1) fc = 2'd2;
        else if (ins[3:0] == 4'd6 && d == 16) fc = 2'd1;
        else begin
          case (ins[3:0])
            4'd0: begin w = {1'b0, s} + {1'b0, t}; r = w[15:0]; c = w[16]; end
            4'd1: begin r = s - t; c = (s >= t); end
            4'd2: r = s & t;
            4'd3: r = s | t;
            4'd4: r = s ^ t;
            4'd9: begin w = {1'b0, s} + {1'b0, t} + {16'h0, m_carry}; r = w[15:0]; c = w[16]; end
            default: ;
          endcase
          case (ins[3:0])
            4'd5: m_stk[d-1] = ~t;
            4'd6: m_stk.push_back(t);
            4'd7: void'(m_stk.pop_back());
            4'd8: begin m_stk[d-1] = s; m_stk[d-2] = t; end
            default: begin void'(m_stk.pop_back()); void'(m_stk.pop_back()); m_stk.push_back(r); end
          endcase
        end
      end
      2'b01: case (ins[15:14])
        2'd0: npc = ins[11:0];
        2'd1: if (d < 1) fc = 2'd2; else begin void'(m_stk.pop_back()); if (t == 0) npc = ins[11:0]; end
        2'd2: if (d < 1) fc = 2'd2; else begin void'(m_stk.pop_back()); if (t[15]) npc = ins[11:0]; end
        default: if (m_carry) npc = ins[11:0];
      endcase
      default: if (ins[15:0] == 16'd1) m_halt = 1'b1; else if (ins[15:0] != 16'd0) fc = 2'd3;
    endcase
    if (fc != 0) begin m_fault = 1'b1; m_fc = fc; end
    else begin m_pc = npc; m_carry = c; end
    e.top = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 16'h0;
    e.depth = 5'(m_stk.size()); e.carry = m_carry; e.halted = m_halt;
    e.fault = m_fault; e.fc = m_fc; e.pc = m_pc;
    sb.push_back(e);
  endtask

  // Scoreboard compare (two negedges after ack) then responder, in one process.
  always @(negedge clk) begin
    exp_t e;
    if (!rstN) begin
      m_stk.delete(); sb.delete();
      m_pc = '0; m_carry = 1'b0; m_halt = 1'b0; m_fault = 1'b0; m_fc = '0;
      pend = '0; cnt = 0; ack = 1'b0;
    end else begin
      if (pend[1]) begin
        e = sb.pop_front();
        chk("sb_top", top, e.top);       chk("sb_depth", depth, e.depth);
        chk("sb_carry", carry, e.carry); chk("sb_halted", halted, e.halted);
        chk("sb_fault", fault, e.fault); chk("sb_fcode", fcode, e.fc);
        chk("sb_pc", addr, e.pc);
        n_exec++;
      end
      pend = {pend[0], 1'b0};
      if (req) begin
        if (cnt >= ack_dly) begin
          ack = 1'b1; instr = imem[addr]; model_exec(imem[addr]); pend[0] = 1'b1;
        end else begin ack = 1'b0; cnt++; end
      end else begin ack = 1'b0; cnt = 0; end
    end
  end

  // Small-stack core sees an endless run of LIT addr+1.
  always @(negedge clk) begin
    ack4 = req4;
    instr4 = {2'b11, 4'h0, addr4 + 12'd1};
  end

  task automatic put(input logic [17:0] w); imem[lp] = w; lp++; endtask
  task automatic org(input int a); lp = a; endtask

  task automatic do_reset();
    @(negedge clk); rstN = 1'b0; run = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4096; i++) imem[i] = HALT;
    lp = 0;
  endtask

  task automatic release_run();
    @(negedge clk); rstN = 1'b1; run = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (halted || fault) break;
    end
    chk(tag, {31'h0, halted | fault}, 32'h1);
  endtask

  task automatic p1();
    put(LIT(16'd5)); put(LIT(16'd3)); put(ALU(4'd0)); put(HALT);
  endtask

  initial begin
    do_reset();
    chk("rst_req", req, 0);   chk("rst_addr", addr, 0); chk("rst_top", top, 0);
    chk("rst_depth", depth, 0); chk("rst_carry", carry, 0);
    chk("rst_halted", halted, 0); chk("rst_fault", fault, 0); chk("rst_fcode", fcode, 0);

    // Basic program, ack one cycle after request
    ack_dly = 1; p1(); release_run();
    wait_done("t1_done");
    chk("t1_top", top, 16'd8); chk("t1_depth", depth, 1); chk("t1_carry", carry, 0);
    chk("t1_halted", halted, 1); chk("t1_pc", addr, 12'd4); chk("t1_req", req, 0);
    for (int i = 0; i < 200; i++) begin @(posedge clk); #1; if (fault4) break; end
    chk("ovf_fault", fault4, 1); chk("ovf_fcode", fcode4, 2'b01); chk("ovf_depth", depth4, 3'd4);
    chk("ovf_top", top4, 16'd4); chk("ovf_pc", addr4, 12'd4); chk("ovf_req", req4, 0);

    // Ack stall stability, then drop run during EXEC
    do_reset(); ack_dly = 3; p1(); release_run();
    for (int i = 0; i < 100; i++) begin @(posedge clk); #1; if (req && addr == 12'd1) break; end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hs_req", req, 1); chk("hs_addr", addr, 12'd1); chk("hs_noack", ack, 0);
    end
    for (int i = 0; i < 20; i++) begin @(posedge clk); if (req && ack) break; end
    #1 run = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("idle_req", req, 0); chk("idle_addr", addr, 12'd2);
    chk("idle_depth", depth, 2); chk("idle_top", top, 16'd3);
    run = 1'b1;
    @(posedge clk); #1;
    chk("resume_req", req, 1); chk("resume_addr", addr, 12'd2);
    wait_done("t1b_done"); chk("t1b_top", top, 16'd8);

    // Carry chain and the rest of the ALU
    do_reset(); ack_dly = 0;
    put(LIT(16'hFFFF)); put(LIT(16'd1)); put(ALU(4'd0)); put(LIT(16'd0)); put(ALU(4'd9));
    put(LIT(16'd3)); put(LIT(16'd5)); put(ALU(4'd8)); put(ALU(4'd1)); put(ALU(4'd6));
    put(ALU(4'd4)); put(ALU(4'd5)); put(LIT(16'h0F0F)); put(ALU(4'd2)); put(LIT(16'd1));
    put(ALU(4'd3)); put(ALU(4'd7)); put(LIT(16'd2)); put(LIT(16'd5)); put(ALU(4'd1));
    put(JMP(2'd3, 12'h000)); put(HALT);
    release_run();
    wait_done("t2_done");
    chk("t2_top", top, 16'hFFFD); chk("t2_depth", depth, 2); chk("t2_carry", carry, 0);

    // Branches and PC wrap; then reset while a fetch is outstanding
    do_reset(); ack_dly = 0;
    put(LIT(16'd1)); put(JMP(2'd1, 12'h010)); put(LIT(16'd0)); put(JMP(2'd1, 12'h010));
    org(12'h010); put(LIT(16'h8000)); put(JMP(2'd2, 12'h020));
    org(12'h020); put(JMP(2'd3, 12'h030)); put(JMP(2'd0, 12'hFFF));
    org(12'hFFF); put(NOP);
    n_exec = 0; release_run();
    for (int i = 0; i < 300; i++) begin @(posedge clk); #1; if (n_exec >= 12) break; end
    chk("t3_execs", {31'h0, n_exec >= 12}, 32'h1);
    ack_dly = 50;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (req) break; end
    chk("mid_req", req, 1);
    #2 rstN = 1'b0;
    #1 chk("mid_rst_req", req, 0); chk("mid_rst_addr", addr, 0); chk("mid_rst_depth", depth, 0);

    // Underflow on an empty stack
    do_reset(); ack_dly = 0; put(ALU(4'd0)); release_run();
    wait_done("t4_done");
    chk("unf_fcode", fcode, 2'b10); chk("unf_depth", depth, 0); chk("unf_pc", addr, 0);

    // Illegal ALU opcode
    do_reset(); put(LIT(16'd7)); put(ALU(4'hA)); release_run();
    wait_done("t5_done");
    chk("ill_fcode", fcode, 2'b11); chk("ill_top", top, 16'd7); chk("ill_pc", addr, 12'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
